// File: rtl/iod_clk_train_eye_ctrl.sv
// iod_clk_train_eye_ctrl
//   Fabric-side clock-training controller for one IOD lane. Each training
//   window clears the lane's eye-monitor flags, waits for them to settle,
//   then counts EARLY/LATE flags over a fixed window and votes. A one-sided
//   vote becomes a phase-step request to the clock phase shifter over a
//   REQ/ACK handshake. LOCK_WINDOWS consecutive clean windows declare lock
//   (TRAIN_DONE). Running out of phase steps declares TRAIN_ERR.
//
//   Optional build macro IOD_TRAIN_PATTERN_CHECK_EN: during SAMPLE, RX_DATA_0
//   must be 4'b1010 or 4'b0101 on every cycle. Otherwise the window is bad,
//   its votes are discarded, and LOCK_WINDOWS bad windows in a row give
//   TRAIN_ERR. When the macro is undefined, RX_DATA_0 is ignored.
//
// Ports
//   FAB_CLK                    sole clock
//   RX_SYNC_RST                synchronous reset, active high
//   TRAIN_START                single-cycle start; ignored while busy
//   EYE_MONITOR_EARLY_0/LATE_0 lane eye-monitor flags
//   RX_DATA_0[3:0]             lane sampled clock pattern
//   EYE_MONITOR_CLEAR_FLAGS_0  2-cycle clear pulse at the start of each window
//   STEP_REQ/STEP_DIR/STEP_ACK phase-step handshake (DIR 1 = delay clock)
//   TRAIN_BUSY/DONE/ERR        status; DONE and ERR are sticky until restart
//   STEP_COUNT                 steps taken in the current run
module iod_clk_train_eye_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 64,
  parameter int VOTE_THRESH   = 8,
  parameter int LOCK_WINDOWS  = 4,
  parameter int MAX_STEPS     = 256
) (
  input  logic                           FAB_CLK,
  input  logic                           RX_SYNC_RST,
  input  logic                           TRAIN_START,
  input  logic                           EYE_MONITOR_EARLY_0,
  input  logic                           EYE_MONITOR_LATE_0,
  input  logic [3:0]                     RX_DATA_0,
  output logic                           EYE_MONITOR_CLEAR_FLAGS_0,
  output logic                           STEP_REQ,
  output logic                           STEP_DIR,
  input  logic                           STEP_ACK,
  output logic                           TRAIN_BUSY,
  output logic                           TRAIN_DONE,
  output logic                           TRAIN_ERR,
  output logic [$clog2(MAX_STEPS+1)-1:0] STEP_COUNT
);

  localparam int SC_W  = $clog2(MAX_STEPS+1);
  localparam int CNT_W = $clog2(SAMPLE_CYCLES+1);
  localparam int LK_W  = $clog2(LOCK_WINDOWS+1);
  localparam int TMAX  = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int TMR_W = $clog2(((TMAX > 2) ? TMAX : 2) + 1);

  localparam logic [TMR_W-1:0] CLR_LAST    = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES-1);
  localparam logic [TMR_W-1:0] SAMPLE_LAST = TMR_W'(SAMPLE_CYCLES-1);
  localparam logic [CNT_W-1:0] THRESH      = CNT_W'(VOTE_THRESH);
  localparam logic [LK_W-1:0]  LOCK_LAST   = LK_W'(LOCK_WINDOWS-1);
  localparam logic [SC_W-1:0]  STEP_LIMIT  = SC_W'(MAX_STEPS);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SETTLE, SAMPLE, DECIDE, STEP, DONE, ERR
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] ec_q, ec_d, lc_q, lc_d;
  logic [LK_W-1:0]  lock_q, lock_d;
  logic [SC_W-1:0]  steps_q, steps_d;
  logic             dir_q, dir_d;
  logic             req_q, req_d;
  // Set when an ACK is taken; a new request waits until ACK is seen low.
  logic             ack_pend_q, ack_pend_d;
  logic             clr_q, busy_q, done_q, err_q;
  logic             vote_e, vote_l, can_req;

`ifdef IOD_TRAIN_PATTERN_CHECK_EN
  logic [LK_W-1:0]  bad_q, bad_d;
  logic             win_bad_q, win_bad_d;
  logic             pat_ok;
  assign pat_ok = (RX_DATA_0 == 4'b1010) || (RX_DATA_0 == 4'b0101);
`else
  logic             rx_data_unused;
  assign rx_data_unused = ^RX_DATA_0;
`endif

  assign vote_e  = (ec_q >= THRESH);
  assign vote_l  = (lc_q >= THRESH);
  // ACK sampled low on this very edge also re-arms the handshake.
  assign can_req = !ack_pend_q || !STEP_ACK;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ec_d       = ec_q;
    lc_d       = lc_q;
    lock_d     = lock_q;
    steps_d    = steps_q;
    dir_d      = dir_q;
    req_d      = req_q;
    ack_pend_d = ack_pend_q && STEP_ACK;
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
    bad_d      = bad_q;
    win_bad_d  = win_bad_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (TRAIN_START) begin
          state_d = CLEAR;
          tmr_d   = '0;
          steps_d = '0;
          lock_d  = '0;
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
          bad_d   = '0;
`endif
        end
      end
      CLEAR: begin
        if (tmr_q == CLR_LAST) begin
          state_d = SETTLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SAMPLE: begin
        ec_d = ec_q + CNT_W'(EYE_MONITOR_EARLY_0);
        lc_d = lc_q + CNT_W'(EYE_MONITOR_LATE_0);
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
        if (!pat_ok) win_bad_d = 1'b1;
`endif
        if (tmr_q == SAMPLE_LAST) begin
          state_d = DECIDE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DECIDE: begin
        ec_d  = '0;
        lc_d  = '0;
        tmr_d = '0;
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
        win_bad_d = 1'b0;
        if (win_bad_q) begin
          // Corrupted window: votes are meaningless, only the bad streak moves.
          lock_d  = '0;
          bad_d   = bad_q + 1'b1;
          state_d = (bad_q == LOCK_LAST) ? ERR : CLEAR;
        end else begin
          bad_d = '0;
`endif
          if (vote_e && vote_l) begin
            lock_d  = '0;
            state_d = CLEAR;
          end else if (vote_e || vote_l) begin
            lock_d = '0;
            dir_d  = vote_e;
            if (steps_q == STEP_LIMIT) begin
              state_d = ERR;
            end else begin
              state_d = STEP;
              req_d   = can_req;
            end
          end else begin
            lock_d  = lock_q + 1'b1;
            state_d = (lock_q == LOCK_LAST) ? DONE : CLEAR;
          end
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
        end
`endif
      end
      STEP: begin
        if (req_q) begin
          if (STEP_ACK) begin
            req_d      = 1'b0;
            steps_d    = steps_q + 1'b1;
            ack_pend_d = 1'b1;
            state_d    = CLEAR;
            tmr_d      = '0;
          end
        end else if (can_req) begin
          req_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      ec_q       <= '0;
      lc_q       <= '0;
      lock_q     <= '0;
      steps_q    <= '0;
      dir_q      <= 1'b0;
      req_q      <= 1'b0;
      ack_pend_q <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
      bad_q      <= '0;
      win_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ec_q       <= ec_d;
      lc_q       <= lc_d;
      lock_q     <= lock_d;
      steps_q    <= steps_d;
      dir_q      <= dir_d;
      req_q      <= req_d;
      ack_pend_q <= ack_pend_d;
      // Status flags are registered from the next state so they line up
      // with the state register.
      clr_q      <= (state_d == CLEAR);
      busy_q     <= (state_d inside {CLEAR, SETTLE, SAMPLE, DECIDE, STEP});
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
      bad_q      <= bad_d;
      win_bad_q  <= win_bad_d;
`endif
    end
  end

  assign EYE_MONITOR_CLEAR_FLAGS_0 = clr_q;
  assign STEP_REQ                  = req_q;
  assign STEP_DIR                  = dir_q;
  assign TRAIN_BUSY                = busy_q;
  assign TRAIN_DONE                = done_q;
  assign TRAIN_ERR                 = err_q;
  assign STEP_COUNT                = steps_q;

endmodule

// File: tb/tb_iod_clk_train_eye_ctrl.sv
// Bench for iod_clk_train_eye_ctrl: drives whole training runs window by
// window with randomized flag placement and predicts each window's outcome
// from the voting rules.
module tb_iod_clk_train_eye_ctrl;
  localparam int SETTLE = 16, SAMPLE = 64, THR = 8, LOCKW = 4, MAXS = 4;
  localparam int SC_W = $clog2(MAXS+1);
`ifdef IOD_TRAIN_PATTERN_CHECK_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  localparam int O_CLEAR = 0, O_STEP = 1, O_DONE = 2, O_ERR = 3;
  localparam int M_QUIET = 0, M_EARLY3 = 1, M_LATE = 2, M_EARLYP = 3,
                 M_BAD = 4, M_AMB = 5, M_RAND = 6;

  logic gclk = 1'b0;
  logic rst, start, early, late, ack;
  logic [3:0] rxd;
  logic clr, req, dir, busy, done, err;
  logic [SC_W-1:0] cnt;
  int checks = 0, errors = 0, cyc = 0;
  int m_lock, m_bad, m_steps;
  bit m_hold;

  iod_clk_train_eye_ctrl #(
    .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE), .VOTE_THRESH(THR),
    .LOCK_WINDOWS(LOCKW), .MAX_STEPS(MAXS)
  ) dut (
    .FAB_CLK(gclk), .RX_SYNC_RST(rst), .TRAIN_START(start),
    .EYE_MONITOR_EARLY_0(early), .EYE_MONITOR_LATE_0(late), .RX_DATA_0(rxd),
    .EYE_MONITOR_CLEAR_FLAGS_0(clr), .STEP_REQ(req), .STEP_DIR(dir),
    .STEP_ACK(ack), .TRAIN_BUSY(busy), .TRAIN_DONE(done), .TRAIN_ERR(err),
    .STEP_COUNT(cnt)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge gclk);
  endtask

  function automatic logic [31:0] outv();
    return {27'd0, clr, req, busy, done, err};
  endfunction

  function automatic logic [31:0] ev(input bit c, input bit r, input bit b, input bit d, input bit e);
    return {27'd0, c, r, b, d, e};
  endfunction

  function automatic int rnd_cnt();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, THR-2);
      1: return THR-1;
      2: return THR;
      default: return $urandom_range(THR+1, SAMPLE);
    endcase
  endfunction

  // Window outcome straight from the voting rules.
  task automatic model_window(input int ec, input int lc, input bit bad,
                              output int oc, output bit d);
    bit e, l;
    e = (ec >= THR);
    l = (lc >= THR);
    d = e;
    if (PAT && bad) begin
      m_lock = 0;
      m_bad++;
      oc = (m_bad == LOCKW) ? O_ERR : O_CLEAR;
    end else begin
      m_bad = 0;
      if (e && l) begin
        m_lock = 0; oc = O_CLEAR;
      end else if (e || l) begin
        m_lock = 0; oc = (m_steps == MAXS) ? O_ERR : O_STEP;
      end else begin
        m_lock++; oc = (m_lock == LOCKW) ? O_DONE : O_CLEAR;
      end
    end
  endtask

  task automatic plan(input int mode, input int w, output int ec, output int lc, output bit bad);
    ec = 0; lc = 0; bad = 1'b0;
    case (mode)
      M_EARLY3: if (w < 3) ec = 10;
      M_LATE:   lc = (w == 0) ? THR : THR-1;
      M_EARLYP: ec = 20;
      M_BAD:    bad = 1'b1;
      M_AMB:    if (w == 1) begin ec = THR; lc = SAMPLE; end
      M_RAND: if (w < 6) begin
        ec = rnd_cnt(); lc = rnd_cnt(); bad = ($urandom_range(0, 7) == 0);
      end
      default: ;
    endcase
  endtask

  // Entered on the first CLEAR cycle; returns on the cycle after DECIDE.
  task automatic do_window(input int ec, input int lc, input bit bad);
    bit eb[SAMPLE];
    bit lb[SAMPLE];
    bit t;
    int bp, j;
    for (int i = 0; i < SAMPLE; i++) begin eb[i] = (i < ec); lb[i] = (i < lc); end
    for (int i = SAMPLE-1; i > 0; i--) begin
      j = $urandom_range(0, i); t = eb[i]; eb[i] = eb[j]; eb[j] = t;
      j = $urandom_range(0, i); t = lb[i]; lb[i] = lb[j]; lb[j] = t;
    end
    bp = $urandom_range(0, SAMPLE-1);
    tick(); chk("clr_len", clr, 1);
    tick(); chk("clr_end", clr, 0);
    for (int i = 0; i < SETTLE; i++) begin
      early = 1'($urandom); late = 1'($urandom); rxd = 4'($urandom);
      start = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < SAMPLE; i++) begin
      early = eb[i]; late = lb[i];
      rxd = (bad && i == bp) ? 4'b1100 : ($urandom_range(0, 1) ? 4'b1010 : 4'b0101);
      tick();
    end
    early = 1'($urandom); late = 1'($urandom); rxd = 4'($urandom);
    chk("decide", outv(), ev(0, 0, 1, 0, 0));
    tick();
    early = 1'b0; late = 1'b0; rxd = 4'b1010;
  endtask

  task automatic run_train(input int mode, input int ack_dly, input bit abort_step,
                           output int fin, output int nwin);
    int ec, lc, oc, t0, d;
    bit bad, dr;
    m_lock = 0; m_bad = 0; m_steps = 0; fin = -1; nwin = 0;
    start = 1'b1; t0 = cyc; tick(); start = 1'b0;
    chk("start", outv(), ev(1, 0, 1, 0, 0));
    chk("start_cnt", cnt, 0);
    for (int w = 0; w < 40; w++) begin
      plan(mode, w, ec, lc, bad);
      do_window(ec, lc, bad);
      nwin++;
      model_window(ec, lc, bad, oc, dr);
      if (w == 0) chk("latency", cyc - t0, 1 + 2 + SETTLE + SAMPLE + 1);
      case (oc)
        O_CLEAR: chk("out_clear", outv(), ev(1, 0, 1, 0, 0));
        O_DONE:  chk("out_done", outv(), ev(0, 0, 0, 1, 0));
        O_ERR:   chk("out_err", outv(), ev(0, 0, 0, 0, 1));
        default: begin
          chk("out_step", outv(), ev(0, !m_hold, 1, 0, 0));
          chk("dir", dir, dr);
        end
      endcase
      chk("count", cnt, m_steps);
      if (oc == O_DONE || oc == O_ERR) begin fin = oc; break; end
      if (oc == O_STEP) begin
        if (m_hold) begin
          tick(); chk("rearm_wait", req, 0);
          ack = 1'b0; m_hold = 1'b0;
          tick(); chk("rearm_req", req, 1);
        end
        if (abort_step) begin
          tick(); chk("pre_rst", req, 1);
          rst = 1'b1;
          tick();
          chk("rst_out", outv(), 0); chk("rst_dir", dir, 0); chk("rst_cnt", cnt, 0);
          rst = 1'b0;
          fin = -2;
          return;
        end
        d = (ack_dly > 0) ? ack_dly : $urandom_range(1, 4);
        for (int k = 1; k < d; k++) begin
          tick(); chk("req_hold", {req, dir}, {1'b1, dr});
        end
        ack = 1'b1;
        tick();
        m_steps++;
        chk("ack_take", outv(), ev(1, 0, 1, 0, 0));
        chk("ack_cnt", cnt, m_steps);
        if (mode == M_RAND && $urandom_range(0, 2) == 0) m_hold = 1'b1;
        else ack = 1'b0;
      end
    end
    if (fin < 0) chk("terminate", 0, 1);
    else begin
      ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("sticky", outv(), (fin == O_DONE) ? ev(0, 0, 0, 1, 0) : ev(0, 0, 0, 0, 1));
        chk("sticky_cnt", cnt, m_steps);
      end
      ack = 1'b0; m_hold = 1'b0;
      tick();
    end
  endtask

  initial begin
    int fin, nw;
    rst = 1'b1; start = 1'b0; early = 1'b0; late = 1'b0; rxd = 4'b1010; ack = 1'b0;
    m_hold = 1'b0;
    repeat (3) tick();
    chk("rst_state", outv(), 0); chk("rst_dir0", dir, 0); chk("rst_cnt0", cnt, 0);
    rst = 1'b0;
    ack = 1'b1; early = 1'b1;
    repeat (3) tick();
    chk("idle_hold", outv(), 0); chk("idle_cnt", cnt, 0);
    ack = 1'b0; early = 1'b0;
    tick();

    run_train(M_EARLY3, 3, 1'b1, fin, nw);
    run_train(M_QUIET, 0, 1'b0, fin, nw);
    chk("quiet_fin", fin, O_DONE); chk("quiet_pulses", nw, LOCKW); chk("quiet_cnt", cnt, 0);
    run_train(M_EARLY3, 3, 1'b0, fin, nw);
    chk("early3_fin", fin, O_DONE); chk("early3_cnt", cnt, 3); chk("early3_win", nw, 7);
    run_train(M_LATE, 0, 1'b0, fin, nw);
    chk("late_fin", fin, O_DONE); chk("late_cnt", cnt, 1);
    run_train(M_EARLYP, 0, 1'b0, fin, nw);
    chk("maxstep_fin", fin, O_ERR); chk("maxstep_cnt", cnt, MAXS); chk("maxstep_win", nw, MAXS+1);
    run_train(M_BAD, 0, 1'b0, fin, nw);
    chk("bad_fin", fin, PAT ? O_ERR : O_DONE); chk("bad_cnt", cnt, 0);
    run_train(M_AMB, 0, 1'b0, fin, nw);
    chk("amb_fin", fin, O_DONE); chk("amb_win", nw, 6);
    for (int r = 0; r < 8; r++) run_train(M_RAND, 0, 1'b0, fin, nw);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
